// File: rtl/meta_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : meta_update_queue                                            |
// | Description : In-order branch tracking queue that issues one registered    |
// |               tournament meta-table update per resolved branch. Define     |
// |               META_FILTER_EN to update only on global/local disagreement.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module meta_update_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc,
    input  logic [IDX_W-1:0] alloc_idx,
    input  logic             alloc_global_pred,
    input  logic             alloc_local_pred,
    input  logic             alloc_chosen_pred,
    output logic             alloc_ready,
    input  logic             resolve,
    input  logic             resolve_taken,
    input  logic             flush,
    output logic             write,
    output logic [IDX_W-1:0] actual_outcome_idx,
    output logic             global_outcome,
    output logic             local_outcome,
    output logic             mispredict,
    output logic [15:0]      misp_count,
    output logic             resolve_err
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic [DEPTH-1:0] gp_mem;
    logic [DEPTH-1:0] lp_mem;
    logic [DEPTH-1:0] cp_mem;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [15:0]      misp_count_q, misp_count_d;
    logic             write_q;
    logic [IDX_W-1:0] idx_q;
    logic             gout_q;
    logic             lout_q;
    logic             misp_q;
    logic             err_q;

    logic w_full;
    logic w_alloc;
    logic w_pop;
    logic w_g_ok;
    logic w_l_ok;
    logic w_misp;
    logic w_wr;

    assign w_full  = (count_q == FULL_CNT);
    assign w_alloc = alloc && !w_full && !flush;
    assign w_pop   = resolve && (count_q != '0);
    assign w_g_ok  = (gp_mem[head_q] == resolve_taken);
    assign w_l_ok  = (lp_mem[head_q] == resolve_taken);
    assign w_misp  = w_pop && (cp_mem[head_q] != resolve_taken);

`ifdef META_FILTER_EN
    // Agreeing predictors carry no information for the chooser.
    assign w_wr = w_pop && (w_g_ok != w_l_ok);
`else
    assign w_wr = w_pop;
`endif

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        misp_count_d = misp_count_q;
        if (w_misp && (misp_count_q != 16'hFFFF)) begin
            misp_count_d = misp_count_q + 16'd1;
        end
        // The same-cycle resolve has already been consumed when flush clears state.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_pop) begin
                head_d = head_q + 1'b1;
            end
            if (w_alloc) begin
                tail_d = tail_q + 1'b1;
            end
            count_d = count_q + (PTR_W + 1)'(w_alloc) - (PTR_W + 1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            idx_mem[tail_q] <= alloc_idx;
            gp_mem[tail_q]  <= alloc_global_pred;
            lp_mem[tail_q]  <= alloc_local_pred;
            cp_mem[tail_q]  <= alloc_chosen_pred;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            misp_count_q <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            gout_q       <= 1'b0;
            lout_q       <= 1'b0;
            misp_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            misp_count_q <= misp_count_d;
            write_q      <= w_wr;
            misp_q       <= w_misp;
            if (w_wr) begin
                idx_q  <= idx_mem[head_q];
                gout_q <= w_g_ok;
                lout_q <= w_l_ok;
            end
            if (resolve && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign alloc_ready        = !w_full;
    assign write              = write_q;
    assign actual_outcome_idx = idx_q;
    assign global_outcome     = gout_q;
    assign local_outcome      = lout_q;
    assign mispredict         = misp_q;
    assign misp_count         = misp_count_q;
    assign resolve_err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_meta_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_meta_update_queue                                         |
// | Description : Scoreboard bench for meta_update_queue with a queue model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_meta_update_queue;

    localparam int DEPTH = 8;
    localparam int IDX_W = 10;
`ifdef META_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             g;
        logic             l;
        logic             c;
    } ent_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             g;
        logic             l;
    } wr_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             alloc;
    logic [IDX_W-1:0] alloc_idx;
    logic             alloc_global_pred;
    logic             alloc_local_pred;
    logic             alloc_chosen_pred;
    logic             alloc_ready;
    logic             resolve;
    logic             resolve_taken;
    logic             flush;
    logic             write;
    logic [IDX_W-1:0] actual_outcome_idx;
    logic             global_outcome;
    logic             local_outcome;
    logic             mispredict;
    logic [15:0]      misp_count;
    logic             resolve_err;

    meta_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc             (alloc),
        .alloc_idx         (alloc_idx),
        .alloc_global_pred (alloc_global_pred),
        .alloc_local_pred  (alloc_local_pred),
        .alloc_chosen_pred (alloc_chosen_pred),
        .alloc_ready       (alloc_ready),
        .resolve           (resolve),
        .resolve_taken     (resolve_taken),
        .flush             (flush),
        .write             (write),
        .actual_outcome_idx(actual_outcome_idx),
        .global_outcome    (global_outcome),
        .local_outcome     (local_outcome),
        .mispredict        (mispredict),
        .misp_count        (misp_count),
        .resolve_err       (resolve_err)
    );

    always #5 clk = ~clk;

    ent_t             mq[$];
    wr_t              exp_q[$];
    int               m_cnt = 0;
    bit               m_err = 1'b0;
    bit               m_misp = 1'b0;
    logic [IDX_W-1:0] last_idx = '0;
    bit               last_g = 1'b0;
    bit               last_l = 1'b0;
    bit               mon_en = 1'b0;
    int               checks = 0;
    int               passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model advances to the state after the next edge.
    task automatic cyc(input bit a, input logic [IDX_W-1:0] idx, input bit g, input bit l,
                       input bit c, input bit r, input bit t, input bit f);
        int   sz;
        ent_t e;
        bit   go, lo;
        @(negedge clk);
        alloc = a; alloc_idx = idx; alloc_global_pred = g; alloc_local_pred = l;
        alloc_chosen_pred = c; resolve = r; resolve_taken = t; flush = f;
        sz     = mq.size();
        m_misp = 1'b0;
        if (r) begin
            if (sz > 0) begin
                e  = mq.pop_front();
                go = (e.g == t);
                lo = (e.l == t);
                if (!FILT || (go != lo)) begin
                    exp_q.push_back('{idx: e.idx, g: go, l: lo});
                    last_idx = e.idx; last_g = go; last_l = lo;
                end
                if (e.c != t) begin
                    m_misp = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (f) mq.delete();
        else if (a && (sz < DEPTH)) mq.push_back('{idx: idx, g: g, l: l, c: c});
    endtask

    always begin
        wr_t w;
        @(posedge clk);
        #1;
        if (mon_en) begin
            chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
            chk("misp_count", misp_count, m_cnt);
            chk("resolve_err", resolve_err, m_err);
            chk("mispredict", mispredict, m_misp);
            if (write) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", write, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_idx", actual_outcome_idx, w.idx);
                    chk("wr_global", global_outcome, w.g);
                    chk("wr_local", local_outcome, w.l);
                end
            end else begin
                chk("missing_write", exp_q.size(), 0);
                chk("hold_idx", actual_outcome_idx, last_idx);
                chk("hold_global", global_outcome, last_g);
                chk("hold_local", local_outcome, last_l);
            end
        end
    end

    initial begin
        rst = 1'b1; alloc = 0; alloc_idx = '0; alloc_global_pred = 0; alloc_local_pred = 0;
        alloc_chosen_pred = 0; resolve = 0; resolve_taken = 0; flush = 0;
        repeat (3) @(negedge clk);
        chk("rst_write", write, 0);
        chk("rst_idx", actual_outcome_idx, 0);
        chk("rst_misp", mispredict, 0);
        chk("rst_misp_count", misp_count, 0);
        chk("rst_err", resolve_err, 0);
        chk("rst_ready", alloc_ready, 1);
        rst    = 1'b0;
        mon_en = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Single alloc/resolve with a mispredict.
        cyc(1, 10'h155, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Fill to full, then a dropped alloc alongside a resolve, then drain.
        for (int i = 0; i < DEPTH; i++) cyc(1, 10'(16 + i), i[0], i[1], i[2], 0, 0, 0);
        cyc(1, 10'h3FF, 1, 1, 1, 1, 1, 0);
        repeat (DEPTH) cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // 20 overlapped pairs through pointer wrap.
        cyc(1, 10'h200, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) cyc(1, 10'(10'h200 + 7 * i), i[0], i[1], i[2], 1, i[1] ^ i[0], 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Resolve plus flush with three in flight, then an underflowing resolve.
        cyc(1, 10'h011, 1, 0, 1, 0, 0, 0);
        cyc(1, 10'h022, 0, 1, 0, 0, 0, 0);
        cyc(1, 10'h033, 1, 1, 1, 0, 0, 0);
        cyc(1, 10'h044, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Agreeing predictors with a wrong chosen prediction.
        cyc(1, 10'h0F0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 60, 10'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $urandom_range(0, 99) < 50, 1'($urandom), $urandom_range(0, 99) < 4);
        end
        repeat (DEPTH + 1) cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset while a write pulse is live.
        cyc(1, 10'h2AA, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("arst_write", write, 0);
        chk("arst_misp_count", misp_count, 0);
        chk("arst_err", resolve_err, 0);
        chk("arst_ready", alloc_ready, 1);
        chk("arst_misp", mispredict, 0);
        mq.delete(); exp_q.delete();
        m_cnt = 0; m_err = 1'b0; m_misp = 1'b0;
        last_idx = '0; last_g = 1'b0; last_l = 1'b0;
        @(negedge clk);
        alloc = 0; resolve = 0; flush = 0;
        rst    = 1'b0;
        mon_en = 1'b1;
        cyc(1, 10'h1C3, 0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        mon_en = 1'b0;
        chk("drain_exp", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/meta_update_queue.md
# meta_update_queue

In-order tracking queue between branch prediction at fetch and branch resolution at execute, feeding the write port of the tournament meta-predictor table. At prediction time it records the meta index and the individual global and local predictions. When the branch resolves, it pops the oldest entry and issues one registered update pulse carrying the per-predictor correctness bits. It also keeps a saturating mispredict counter and a sticky error flag for underflow.

## Interface
Parameters:
- DEPTH, 8: number of in-flight branch entries; a power of two, at least 2.
- IDX_W, 10: meta-table index width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- alloc  in  1  fetch predicted a branch this cycle; record an entry.
- alloc_idx  in  IDX_W  meta-table index of the branch.
- alloc_global_pred  in  1  global predictor's taken prediction.
- alloc_local_pred  in  1  local predictor's taken prediction.
- alloc_chosen_pred  in  1  final prediction used by fetch.
- alloc_ready  out  1  queue can accept an entry; equals !full.
- resolve  in  1  oldest in-flight branch resolved this cycle.
- resolve_taken  in  1  actual outcome of the resolving branch.
- flush  in  1  discard all entries remaining after this cycle's resolve.
- write  out  1  one-cycle update pulse to the meta table.
- actual_outcome_idx  out  IDX_W  index of the entry being updated.
- global_outcome  out  1  global predictor was correct.
- local_outcome  out  1  local predictor was correct.
- mispredict  out  1  one-cycle pulse: chosen prediction != resolve_taken.
- misp_count  out  16  saturating count of mispredicts.
- resolve_err  out  1  sticky; set when resolve arrives while the queue is empty.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {idx, global_pred, local_pred, chosen_pred}.
- State is a head pointer, a tail pointer and a count of width log2(DEPTH)+1. Both pointers wrap modulo DEPTH.
- Allocate:
  - Condition: alloc && alloc_ready && !flush.
  - Action: write the entry at tail, then advance tail.
  - alloc while full is dropped and queue state is unchanged; fetch must hold the request until alloc_ready is high.
- Resolve with count > 0:
  - Pop the head entry.
  - global_outcome = (global_pred == resolve_taken); local_outcome = (local_pred == resolve_taken).
  - mispredict = (chosen_pred != resolve_taken).
- Resolve with count == 0: no pop, no write, no mispredict; set resolve_err, which stays set until rst.
- Simultaneous alloc and resolve, not full and not flush: both take effect and count is unchanged. If the queue is empty, the popped entry is not the same-cycle alloc; this case is treated as underflow.
- alloc_ready is a function of count only. A resolve in the same cycle does not free a slot for a same-cycle alloc when the queue is full.
- flush:
  - A same-cycle resolve is processed first, including its write pulse.
  - Then head, tail and count reset to 0 and any same-cycle alloc is dropped.
- misp_count increments on each mispredict pulse and saturates at 16'hFFFF.
- Exactly one write pulse per popped entry at most, because the meta table performs a read-modify-write and must see only one write per branch.

## Timing
- Reset values: write=0, actual_outcome_idx=0, global_outcome=0, local_outcome=0, mispredict=0, misp_count=0, resolve_err=0, alloc_ready=1, count=0, head=tail=0.
- alloc_ready is combinational from registered count.
- write, actual_outcome_idx, global_outcome, local_outcome and mispredict are registered: they are valid in the cycle after the resolve edge and last exactly one cycle.
- Data outputs hold their last values while write is low.
- Back-to-back resolves produce back-to-back write pulses with no bubble.
- Latency from an alloc edge to that entry being poppable is 1 cycle.
- rst asserted mid-operation clears all state immediately. A pending write pulse is cancelled.

## Configuration
- META_FILTER_EN defined: the write pulse is suppressed when global_outcome == local_outcome, so only disagreements update the meta table. The entry is still popped, and mispredict and misp_count still update.
- META_FILTER_EN not defined: every pop issues a write pulse.

## Test plan
- Reset, then alloc idx=0x155 with global=1, local=0, chosen=1, then resolve_taken=0 -> next cycle write=1, actual_outcome_idx=0x155, global_outcome=0, local_outcome=1, mispredict=1, misp_count=1.
- Alloc 8 entries (DEPTH=8) -> alloc_ready=0. A 9th alloc with a simultaneous resolve -> the 9th alloc is dropped; count becomes 7 and alloc_ready=1.
- 20 alloc/resolve pairs with rotating indices through pointer wrap -> write indices come out in allocation order with no duplicates.
- 3 entries in flight, then resolve plus flush in the same cycle -> one write for the oldest entry; count=0; a following resolve sets resolve_err=1 and produces no write.
- With META_FILTER_EN: resolve an entry with global=1, local=1, taken=1 -> no write pulse, entry popped, mispredict per chosen. Without META_FILTER_EN: the same stimulus gives write=1 with global_outcome=1 and local_outcome=1.
- Assert rst asynchronously while a resolve is in flight -> write=0 immediately, count=0, misp_count=0, resolve_err=0.
